// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: loads a 64-bit key and hands out the 16 round subkeys,
// one per valid/ready handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:64] key_in,
  input  logic        decrypt,
  input  logic        subkey_ready,
  output logic [1:48] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [1:28] c_q, c_d;
  logic [1:28] d_q, d_d;
  logic [3:0]  n_q, n_d;
  logic        dir_q, dir_d;

  logic [1:56] pc1_key;
  logic [1:56] cd;
  logic [4:0]  r_enc;
  logic [4:0]  r_dec;

  function automatic logic [1:28] rotl(input logic [1:28] x, input logic two);
    rotl = two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
  endfunction

  function automatic logic [1:28] rotr(input logic [1:28] x, input logic two);
    rotr = two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
  endfunction

  // Rounds 1, 2, 9 and 16 rotate by one; every other round rotates by two.
  function automatic logic shift_two(input logic [4:0] r);
    shift_two = !((r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16));
  endfunction

  // PC-1: drops the parity bits and permutes the remaining 56 into C||D.
  assign pc1_key = {
    key_in[57], key_in[49], key_in[41], key_in[33], key_in[25], key_in[17], key_in[9],
    key_in[1],  key_in[58], key_in[50], key_in[42], key_in[34], key_in[26], key_in[18],
    key_in[10], key_in[2],  key_in[59], key_in[51], key_in[43], key_in[35], key_in[27],
    key_in[19], key_in[11], key_in[3],  key_in[60], key_in[52], key_in[44], key_in[36],
    key_in[63], key_in[55], key_in[47], key_in[39], key_in[31], key_in[23], key_in[15],
    key_in[7],  key_in[62], key_in[54], key_in[46], key_in[38], key_in[30], key_in[22],
    key_in[14], key_in[6],  key_in[61], key_in[53], key_in[45], key_in[37], key_in[29],
    key_in[21], key_in[13], key_in[5],  key_in[28], key_in[20], key_in[12], key_in[4]
  };

  logic unused_parity;
  assign unused_parity = ^{key_in[8], key_in[16], key_in[24], key_in[32],
                           key_in[40], key_in[48], key_in[56], key_in[64]};

  assign cd = {c_q, d_q};

  // PC-2: selects 48 of the 56 C||D bits.
  assign subkey = {
    cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],
    cd[3],  cd[28], cd[15], cd[6],  cd[21], cd[10],
    cd[23], cd[19], cd[12], cd[4],  cd[26], cd[8],
    cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
    cd[41], cd[52], cd[31], cd[37], cd[47], cd[55],
    cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
    cd[44], cd[49], cd[39], cd[56], cd[34], cd[53],
    cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]
  };

  logic unused_cd;
  assign unused_cd = ^{cd[9], cd[18], cd[22], cd[25], cd[35], cd[38], cd[43], cd[54]};

  // Next round to be produced: encrypt moves forward, decrypt steps C||D backwards.
  assign r_enc = {1'b0, n_q} + 5'd2;
  assign r_dec = 5'd16 - {1'b0, n_q};

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    n_d     = n_q;
    dir_d   = dir_q;

    if (start) begin
      // Decrypt needs no rotation: the full schedule rotates by 28, i.e. C16||D16 = C0||D0.
      c_d     = decrypt ? pc1_key[1:28]  : rotl(pc1_key[1:28], 1'b0);
      d_d     = decrypt ? pc1_key[29:56] : rotl(pc1_key[29:56], 1'b0);
      dir_d   = decrypt;
      n_d     = 4'd0;
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (subkey_ready) begin
            if (n_q == 4'd15) begin
              state_d = StDone;
            end else begin
              if (dir_q) begin
                c_d = rotr(c_q, shift_two(r_dec));
                d_d = rotr(d_q, shift_two(r_dec));
              end else begin
                c_d = rotl(c_q, shift_two(r_enc));
                d_d = rotl(d_q, shift_two(r_enc));
              end
              n_d = n_q + 4'd1;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      c_q     <= '0;
      d_q     <= '0;
      n_q     <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      n_q     <= n_d;
      dir_q   <= dir_d;
    end
  end

  assign subkey_valid = (state_q == StRun);
  assign busy         = (state_q == StRun);
  assign done         = (state_q == StDone);
  assign round        = dir_q ? (4'd15 - n_q) : n_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 133457799BBCDFF1 key schedule.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:64] key_in;
  logic        decrypt;
  logic        subkey_ready;
  logic [1:48] subkey;
  logic        subkey_valid;
  logic [3:0]  round;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] KeyA   = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] KeyPar = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] KeyOne = 64'hFFFF_FFFF_FFFF_FFFF;

  logic [47:0] k_exp [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round        (round),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full schedule, optionally stalling stall_len cycles while holding index stall_at.
  task automatic run_sched(input logic [63:0] key, input logic dec, input int stall_at,
                           input int stall_len, input logic ones);
    int   e;
    int   stalled;
    int   vcyc;
    int   idx;
    logic got_done;
    e        = 0;
    stalled  = 0;
    vcyc     = 0;
    got_done = 1'b0;
    start        = 1'b1;
    key_in       = key;
    decrypt      = dec;
    subkey_ready = 1'b0;
    tick();
    start   = 1'b0;
    key_in  = ~key;
    decrypt = ~dec;
    check("first_valid", 64'(subkey_valid), 64'd1);
    for (int cyc = 0; cyc < 64 && !got_done; cyc++) begin
      if (done) begin
        got_done = 1'b1;
        check("valid_at_done", 64'(subkey_valid), 64'd0);
        check("busy_at_done", 64'(busy), 64'd0);
      end else if (subkey_valid) begin
        idx = dec ? 15 - (e % 16) : (e % 16);
        vcyc++;
        check("subkey", 64'(subkey), ones ? 64'hFFFF_FFFF_FFFF : 64'(k_exp[idx]));
        check("round", 64'(round), 64'(idx));
        check("busy", 64'(busy), 64'd1);
        if (e == stall_at && stalled < stall_len) begin
          subkey_ready = 1'b0;
          stalled++;
        end else begin
          subkey_ready = 1'b1;
          e++;
        end
      end else begin
        subkey_ready = 1'b1;
      end
      tick();
    end
    check("done_seen", 64'(got_done), 64'd1);
    check("accepted", 64'(e), 64'd16);
    check("valid_cycles", 64'(vcyc), 64'(16 + stall_len));
    check("done_width", 64'(done), 64'd0);
    subkey_ready = 1'b0;
  endtask

  initial begin
    int ndone;
    rst          = 1'b1;
    start        = 1'b0;
    key_in       = '0;
    decrypt      = 1'b0;
    subkey_ready = 1'b0;
    #12;
    check("rst_valid", 64'(subkey_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_round", 64'(round), 64'd0);
    check("rst_subkey", 64'(subkey), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    subkey_ready = 1'b1;
    tick();
    tick();
    check("idle_valid", 64'(subkey_valid), 64'd0);
    subkey_ready = 1'b0;

    run_sched(KeyA, 1'b0, -1, 0, 1'b0);
    run_sched(KeyA, 1'b1, -1, 0, 1'b0);
    run_sched(KeyA, 1'b0, 4, 3, 1'b0);
    run_sched(KeyA, 1'b1, 9, 2, 1'b0);
    run_sched(KeyPar, 1'b0, -1, 0, 1'b0);

    // Abort key A after 5 acceptances with an all-ones decrypt load.
    start = 1'b1; key_in = KeyA; decrypt = 1'b0;
    tick();
    start = 1'b0; subkey_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("abort_pre_round", 64'(round), 64'd5);
    check("abort_pre_subkey", 64'(subkey), 64'(k_exp[5]));
    start = 1'b1; key_in = KeyOne; decrypt = 1'b1;
    tick();
    start = 1'b0;
    check("abort_subkey", 64'(subkey), 64'hFFFF_FFFF_FFFF);
    check("abort_round", 64'(round), 64'd15);
    check("abort_valid", 64'(subkey_valid), 64'd1);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) ndone++;
      tick();
    end
    check("abort_done_count", 64'(ndone), 64'd1);

    // Start coinciding with the final acceptance: reload wins, no done pulse.
    start = 1'b1; key_in = KeyA; decrypt = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("coll_round", 64'(round), 64'd15);
    check("coll_subkey", 64'(subkey), 64'(k_exp[15]));
    start = 1'b1;
    tick();
    start = 1'b0;
    subkey_ready = 1'b0;
    check("coll_done", 64'(done), 64'd0);
    check("coll_valid", 64'(subkey_valid), 64'd1);
    check("coll_subkey1", 64'(subkey), 64'(k_exp[0]));
    check("coll_round0", 64'(round), 64'd0);
    tick();
    check("coll_done_next", 64'(done), 64'd0);

    // Asynchronous reset between edges while holding round 7.
    start = 1'b1; key_in = KeyA; decrypt = 1'b0; subkey_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    subkey_ready = 1'b0;
    check("ar_pre_round", 64'(round), 64'd7);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", 64'(subkey_valid), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_round", 64'(round), 64'd0);
    check("ar_subkey", 64'(subkey), 64'd0);
    #2;
    rst = 1'b0;
    subkey_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ar_idle_valid", 64'(subkey_valid), 64'd0);
      check("ar_idle_busy", 64'(busy), 64'd0);
    end
    subkey_ready = 1'b0;
    run_sched(KeyPar, 1'b1, -1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Sequential DES key-schedule generator, one stage upstream of the S-box bank.
- Loads a 64-bit DES key and emits the 16 48-bit round subkeys, one per handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).
- The round engine XORs each subkey with the expanded R half; the result feeds the S1..S8 lookups.
- All tables (PC-1, PC-2, shift schedule) are per FIPS 46-3, with bit 1 as the MSB.

Parameters:
- None. DES widths and tables are fixed.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- start  input  1  single-cycle load strobe; samples key_in and decrypt
- key_in  input  [1:64]  DES key, bit 1 = MSB; parity bits 8,16,...,64 are ignored
- decrypt  input  1  0 = K1..K16 order, 1 = K16..K1 order
- subkey_ready  input  1  consumer accepts the current subkey
- subkey  output  [1:48]  current round subkey, PC-2 of C||D
- subkey_valid  output  1  subkey holds a valid round key
- round  output  4  index of the held subkey minus 1 (0 = K1 ... 15 = K16), in both directions
- busy  output  1  high from the start edge until the last subkey is accepted
- done  output  1  one-cycle pulse after K-final is accepted

Behaviour:
- Reset (async, any time):
  - State = IDLE; C = 0, D = 0, counter = 0, dir = 0.
  - subkey = 0, subkey_valid = 0, round = 0, busy = 0, done = 0.
- Registers:
  - 28-bit C and D.
  - 4-bit step counter n (subkeys delivered so far).
  - dir flag, latched from decrypt at start.
- Shift table, indexed by round r = 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (total 28).
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 loads C||D = PC1(key_in) and latches dir.
  - Encrypt: C and D are additionally rotated left by 1 in the same edge (yields K1).
  - Decrypt: no rotation (the total rotation of 28 is the identity, so this yields K16).
  - n = 0; go to RUN.
  - subkey_valid is high in the first cycle after the start edge (latency 1).
- RUN:
  - subkey is combinational PC2(C||D) from registers; it is stable while subkey_valid=1.
  - round = n for encrypt, 15-n for decrypt.
  - On subkey_valid && subkey_ready with n<15:
    - Encrypt: rotate left by shift[n+2].
    - Decrypt: rotate right by shift[16-n].
    - n++.
    - subkey_valid stays high, so back-to-back acceptance gives one subkey per cycle.
  - On acceptance with n=15: go to DONE; subkey_valid=0, busy=0.
  - subkey_ready=0: hold all state indefinitely.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - subkey retains its last value; the consumer must ignore it when valid=0.
- start while in RUN or DONE:
  - Aborts the current schedule and reloads exactly as from IDLE.
  - No done pulse is generated for the aborted schedule.
  - start takes priority over a simultaneous subkey_ready.
- start in the same cycle as the final acceptance: the reload wins; done is not pulsed.
- subkey_ready while subkey_valid=0: ignored.
- start or key_in/decrypt changes outside a start strobe: no effect.
- Rotations are circular within each 28-bit half: a left rotate takes bit 1 to position 28; a right rotate takes bit 28 to position 1.

Test Plan:
- Encrypt, key 133457799BBCDFF1, subkey_ready tied 1:
  - 1 cycle after start: subkey=1B02EFFC7072, round=0.
  - Next cycle: 79AED9DBC9E5, round=1.
  - 16th valid cycle: CB3D8B0E17F5, round=15.
  - done pulses on the following cycle; 16 contiguous valid cycles total.
- Decrypt, same key, ready=1:
  - First subkey=CB3D8B0E17F5, round=15.
  - Second subkey equals the encrypt-run K15.
  - Last subkey=1B02EFFC7072, round=0.
- Backpressure: drop subkey_ready randomly (e.g. low 3 cycles at round 4):
  - subkey and round are frozen while low.
  - The sequence matches the unstalled run exactly.
  - done appears only after the 16th acceptance.
- Abort: start with key A, accept 5 subkeys, then start with key B plus decrypt:
  - Next cycle gives K16(B) with round=15.
  - No done pulse occurs for key A.
- Async reset mid-RUN (assert between clock edges at round 7):
  - subkey_valid, busy, round and subkey go to 0 immediately, without waiting for a clock edge.
  - After release, the block idles until the next start.
- Parity independence: keys 133457799BBCDFF1 and 123456789ABCDEF0 share the same 56 non-parity bits, so both produce an identical 16-subkey sequence.
